// File: rtl/riscv_tb_pkg.sv
// Shared types and defaults for the riscv run-control slice.
// State encoding is visible to the harness through state_o.
package riscv_tb_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALTED   = 2'd2,
    TIMEOUT  = 2'd3
  } run_state_e;

endpackage

// File: rtl/riscv_pc_trace_buf.sv
// Circular PC history: newest entry at index 0, reads past count give 0.
// Only instantiated when RISCV_RUN_CTRL_TRACE_EN is defined.
module riscv_pc_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clr_i,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic [IW-1:0]   idx_i,
  output logic [XLEN-1:0] rd_pc_o,
  output logic [IW:0]     cnt_o
);

  localparam logic [IW:0] FULL = (IW+1)'(DEPTH);

  logic [XLEN-1:0] mem_q [DEPTH];
  logic [IW-1:0]   wptr_q, wptr_d;
  logic [IW:0]     cnt_q, cnt_d;
  logic [IW-1:0]   rd_ptr;

  always_comb begin
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      wptr_d = '0;
      cnt_d  = '0;
    end else if (wr_en_i) begin
      wptr_d = wptr_q + IW'(1);
      if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries beyond cnt_q are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) mem_q[wptr_q] <= wr_pc_i;
  end

  assign rd_ptr  = wptr_q - IW'(1) - idx_i;
  assign rd_pc_o = ({1'b0, idx_i} < cnt_q) ? mem_q[rd_ptr] : '0;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/riscv_run_ctrl.sv
// Core run control: reset sequencing, retire count, self-loop halt, watchdog.
// Define RISCV_RUN_CTRL_TRACE_EN to add the deduplicated PC trace ports.
module riscv_run_ctrl
  import riscv_tb_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 2000,
  parameter int HALT_CYCLES  = 8,
  parameter int TRACE_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             restart_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             pc_valid_i,
  output logic             core_rst_n_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic             done_o,
  output logic             halt_o,
  output logic             timeout_o,
  output logic [1:0]       state_o
`ifdef RISCV_RUN_CTRL_TRACE_EN
  ,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx_i,
  output logic [XLEN-1:0]                trace_pc_o,
  output logic [$clog2(TRACE_DEPTH):0]   trace_cnt_o
`endif
);

  localparam int RW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HALT_CYCLES);
  localparam logic [RW-1:0]    RST_LAST  = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]    SAME_LAST = SW'(HALT_CYCLES - 2);
  localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WDOG_EN   = (MAX_CYCLES != 0);

  if (RESET_CYCLES < 1) begin : g_bad_rst
    $error("RESET_CYCLES must be >= 1");
  end
  if (HALT_CYCLES < 2) begin : g_bad_halt
    $error("HALT_CYCLES must be >= 2");
  end

  run_state_e       state_q, state_d;
  logic             core_rst_n_q, core_rst_n_d;
  logic [RW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic             done_q, done_d;
  logic             halt_q, halt_d;
  logic             timeout_q, timeout_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic             last_pc_vld_q, last_pc_vld_d;
  logic [SW-1:0]    same_cnt_q, same_cnt_d;

  logic in_run, restart, rst_done, pc_match, halt_hit, tmo_hit;

  assign in_run   = (state_q == RUN);
  assign restart  = restart_i && (state_q != RST_HOLD);
  assign rst_done = (state_q == RST_HOLD) && (rst_cnt_q == RST_LAST);
  assign pc_match = last_pc_vld_q && (pc_i == last_pc_q);
  assign halt_hit = in_run && pc_valid_i && pc_match
                    && (same_cnt_q == SAME_LAST);
  assign tmo_hit  = in_run && WDOG_EN && (cycle_cnt_q == CYC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RST_HOLD;
      core_rst_n_q  <= 1'b0;
      rst_cnt_q     <= '0;
      cycle_cnt_q   <= '0;
      retire_cnt_q  <= '0;
      done_q        <= 1'b0;
      halt_q        <= 1'b0;
      timeout_q     <= 1'b0;
      last_pc_q     <= '0;
      last_pc_vld_q <= 1'b0;
      same_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      core_rst_n_q  <= core_rst_n_d;
      rst_cnt_q     <= rst_cnt_d;
      cycle_cnt_q   <= cycle_cnt_d;
      retire_cnt_q  <= retire_cnt_d;
      done_q        <= done_d;
      halt_q        <= halt_d;
      timeout_q     <= timeout_d;
      last_pc_q     <= last_pc_d;
      last_pc_vld_q <= last_pc_vld_d;
      same_cnt_q    <= same_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RST_HOLD: if (rst_done) state_d = RUN;
      RUN: begin
        if (halt_hit)     state_d = HALTED;
        else if (tmo_hit) state_d = TIMEOUT;
      end
      default: ;
    endcase
    if (restart) state_d = RST_HOLD;
  end

  always_comb begin
    core_rst_n_d  = core_rst_n_q;
    rst_cnt_d     = rst_cnt_q;
    cycle_cnt_d   = cycle_cnt_q;
    retire_cnt_d  = retire_cnt_q;
    done_d        = done_q;
    halt_d        = halt_q;
    timeout_d     = timeout_q;
    last_pc_d     = last_pc_q;
    last_pc_vld_d = last_pc_vld_q;
    same_cnt_d    = same_cnt_q;
    if (restart) begin
      core_rst_n_d  = 1'b0;
      rst_cnt_d     = '0;
      cycle_cnt_d   = '0;
      retire_cnt_d  = '0;
      done_d        = 1'b0;
      halt_d        = 1'b0;
      timeout_d     = 1'b0;
      last_pc_d     = '0;
      last_pc_vld_d = 1'b0;
      same_cnt_d    = '0;
    end else if (state_q == RST_HOLD) begin
      rst_cnt_d = rst_cnt_q + RW'(1);
      if (rst_done) core_rst_n_d = 1'b1;
    end else if (in_run) begin
      if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
      if (pc_valid_i) begin
        if (retire_cnt_q != '1) retire_cnt_d = retire_cnt_q + 1'b1;
        if (pc_match) begin
          same_cnt_d = same_cnt_q + SW'(1);
        end else begin
          same_cnt_d    = '0;
          last_pc_d     = pc_i;
          last_pc_vld_d = 1'b1;
        end
      end
      if (halt_hit) begin
        halt_d = 1'b1;
        done_d = 1'b1;
      end else if (tmo_hit) begin
        timeout_d = 1'b1;
        done_d    = 1'b1;
      end
    end
  end

  assign core_rst_n_o = core_rst_n_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign retire_cnt_o = retire_cnt_q;
  assign done_o       = done_q;
  assign halt_o       = halt_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;

`ifdef RISCV_RUN_CTRL_TRACE_EN
  logic trace_wr;
  assign trace_wr = in_run && pc_valid_i && !pc_match && !restart;

  riscv_pc_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (restart),
    .wr_en_i (trace_wr),
    .wr_pc_i (pc_i),
    .idx_i   (trace_idx_i),
    .rd_pc_o (trace_pc_o),
    .cnt_o   (trace_cnt_o)
  );
`endif

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl (RESET 2, MAX 50, HALT 8, TRACE 4).
// Trace scenario is compiled in only with RISCV_RUN_CTRL_TRACE_EN.
module tb_riscv_run_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        restart_i = 1'b0;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        core_rst_n_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] retire_cnt_o;
  logic        done_o, halt_o, timeout_o;
  logic [1:0]  state_o;
`ifdef RISCV_RUN_CTRL_TRACE_EN
  logic [1:0]  trace_idx_i = '0;
  logic [31:0] trace_pc_o;
  logic [2:0]  trace_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_run_ctrl #(
    .XLEN         (32),
    .CNT_W        (32),
    .RESET_CYCLES (2),
    .MAX_CYCLES   (50),
    .HALT_CYCLES  (8),
    .TRACE_DEPTH  (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .restart_i    (restart_i),
    .pc_i         (pc_i),
    .pc_valid_i   (pc_valid_i),
    .core_rst_n_o (core_rst_n_o),
    .cycle_cnt_o  (cycle_cnt_o),
    .retire_cnt_o (retire_cnt_o),
    .done_o       (done_o),
    .halt_o       (halt_o),
    .timeout_o    (timeout_o),
    .state_o      (state_o)
`ifdef RISCV_RUN_CTRL_TRACE_EN
    ,
    .trace_idx_i  (trace_idx_i),
    .trace_pc_o   (trace_pc_o),
    .trace_cnt_o  (trace_cnt_o)
`endif
  );

  // {state, core_rst_n, done, halt, timeout}
  logic [5:0] st;
  assign st = {state_o, core_rst_n_o, done_o, halt_o, timeout_o};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pc_valid_i = 1'b0;
    restart_i  = 1'b0;
    reset_n    = 1'b0;
    #3;
    reset_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if (st !== 6'b00_0_000) begin
      failures++;
      $display("FAIL reset_status got=%b exp=%b", st, 6'b000000);
    end
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== 64'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cycle_cnt_o, retire_cnt_o);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    checks++;
    if (st !== 6'b00_0_000) begin
      failures++;
      $display("FAIL hold_edge1 got=%b exp=%b", st, 6'b000000);
    end
    tick();
    checks++;
    if (st !== 6'b01_1_000) begin
      failures++;
      $display("FAIL run_edge2 got=%b exp=%b", st, 6'b011000);
    end
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== 64'd0) begin
      failures++;
      $display("FAIL run_entry_cnt got=%0d/%0d exp=0/0", cycle_cnt_o, retire_cnt_o);
    end
  endtask

  task automatic test_self_loop();
    logic [31:0] seq [10] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8,
                              32'h8, 32'h8, 32'h8, 32'h8, 32'h8};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      pc_i = seq[i];
      pc_valid_i = 1'b1;
      tick();
      if (i == 8) begin
        checks++;
        if (st !== 6'b01_1_000) begin
          failures++;
          $display("FAIL loop_7th got=%b exp=%b", st, 6'b011000);
        end
      end
    end
    checks++;
    if (st !== 6'b10_1_110) begin
      failures++;
      $display("FAIL loop_halt got=%b exp=%b", st, 6'b101110);
    end
    checks++;
    if (retire_cnt_o !== 32'd10) begin
      failures++;
      $display("FAIL loop_retire got=%0d exp=10", retire_cnt_o);
    end
    tick();
    tick();
    pc_valid_i = 1'b0;
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== {32'd10, 32'd10}) begin
      failures++;
      $display("FAIL loop_frozen got=%0d/%0d exp=10/10", cycle_cnt_o, retire_cnt_o);
    end
  endtask

  task automatic test_gap();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      pc_i = 32'h40;
      pc_valid_i = 1'b1;
      tick();
      if (k < 7) begin
        pc_valid_i = 1'b0;
        tick();
      end
    end
    pc_valid_i = 1'b0;
    checks++;
    if (st !== 6'b10_1_110) begin
      failures++;
      $display("FAIL gap_halt got=%b exp=%b", st, 6'b101110);
    end
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== {32'd15, 32'd8}) begin
      failures++;
      $display("FAIL gap_cnt got=%0d/%0d exp=15/8", cycle_cnt_o, retire_cnt_o);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      pc_i = 32'h1000 + 32'(i * 4);
      pc_valid_i = 1'b1;
      tick();
      if (i == 49) begin
        checks++;
        if (st !== 6'b01_1_000 || cycle_cnt_o !== 32'd49) begin
          failures++;
          $display("FAIL wdog_49 got=%b/%0d exp=011000/49", st, cycle_cnt_o);
        end
      end
    end
    checks++;
    if (st !== 6'b11_1_101) begin
      failures++;
      $display("FAIL wdog_tmo got=%b exp=%b", st, 6'b111101);
    end
    tick();
    pc_valid_i = 1'b0;
    checks++;
    if (cycle_cnt_o !== 32'd50) begin
      failures++;
      $display("FAIL wdog_frozen got=%0d exp=50", cycle_cnt_o);
    end
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    checks++;
    if (st !== 6'b00_0_000 || cycle_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL wdog_restart got=%b/%0d exp=000000/0", st, cycle_cnt_o);
    end
  endtask

  task automatic test_collision();
    do_reset();
    for (int i = 1; i <= 50; i++) begin
      pc_i = (i <= 42) ? 32'(i * 4) : 32'h100;
      pc_valid_i = 1'b1;
      tick();
    end
    pc_valid_i = 1'b0;
    checks++;
    if (st !== 6'b10_1_110) begin
      failures++;
      $display("FAIL collide_status got=%b exp=%b", st, 6'b101110);
    end
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== {32'd50, 32'd50}) begin
      failures++;
      $display("FAIL collide_cnt got=%0d/%0d exp=50/50", cycle_cnt_o, retire_cnt_o);
    end
  endtask

  task automatic test_restart();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      pc_i = 32'h2000 + 32'(i * 4);
      pc_valid_i = 1'b1;
      tick();
    end
    pc_valid_i = 1'b0;
    checks++;
    if (cycle_cnt_o !== 32'd20) begin
      failures++;
      $display("FAIL rs_pre got=%0d exp=20", cycle_cnt_o);
    end
    restart_i = 1'b1;
    tick();
    checks++;
    if (st !== 6'b00_0_000) begin
      failures++;
      $display("FAIL rs_hold got=%b exp=%b", st, 6'b000000);
    end
    checks++;
    if ({cycle_cnt_o, retire_cnt_o} !== 64'd0) begin
      failures++;
      $display("FAIL rs_cnt got=%0d/%0d exp=0/0", cycle_cnt_o, retire_cnt_o);
    end
    tick();
    checks++;
    if (st !== 6'b00_0_000) begin
      failures++;
      $display("FAIL rs_edge1 got=%b exp=%b", st, 6'b000000);
    end
    tick();
    restart_i = 1'b0;
    checks++;
    if (st !== 6'b01_1_000 || cycle_cnt_o !== 32'd0) begin
      failures++;
      $display("FAIL rs_edge2 got=%b/%0d exp=011000/0", st, cycle_cnt_o);
    end
  endtask

`ifdef RISCV_RUN_CTRL_TRACE_EN
  task automatic test_trace();
    logic [31:0] seq [6] = '{32'h10, 32'h14, 32'h14, 32'h18, 32'h1C, 32'h20};
    logic [31:0] exp_pc [4] = '{32'h20, 32'h1C, 32'h18, 32'h14};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      pc_i = seq[i];
      pc_valid_i = 1'b1;
      tick();
    end
    pc_valid_i = 1'b0;
    checks++;
    if (trace_cnt_o !== 3'd4) begin
      failures++;
      $display("FAIL trace_cnt got=%0d exp=4", trace_cnt_o);
    end
    for (int i = 0; i < 4; i++) begin
      trace_idx_i = 2'(i);
      #1;
      checks++;
      if (trace_pc_o !== exp_pc[i]) begin
        failures++;
        $display("FAIL trace_idx%0d got=%h exp=%h", i, trace_pc_o, exp_pc[i]);
      end
    end
    restart_i = 1'b1;
    tick();
    restart_i = 1'b0;
    trace_idx_i = 2'd0;
    #1;
    checks++;
    if ({trace_cnt_o, trace_pc_o} !== 35'd0) begin
      failures++;
      $display("FAIL trace_clr got=%0d/%h exp=0/0", trace_cnt_o, trace_pc_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_self_loop();
    test_gap();
    test_watchdog();
    test_collision();
    test_restart();
`ifdef RISCV_RUN_CTRL_TRACE_EN
    test_trace();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
